// File: rtl/fir_sum_reader.sv
// fir_sum_reader: drains the FIR core sum queue, rescales Q15 sums
// to saturated OUT_W samples and streams them out of a 2-entry FIFO.
// Ports: clk3/reset (sync, active-high); empty/read/sum to core;
//   out_data/out_valid/out_ready stream; sat_cnt saturation count.
// Option: define FIR_SUM_ROUND_EN to round half up before the shift.
module fir_sum_reader #(
   parameter int SUM_W  = 32,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 15,
   parameter int RD_LAT = 1
) (
   input  logic             clk3,
   input  logic             reset,
   input  logic             empty,
   output logic             read,
   input  logic [SUM_W-1:0] sum,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       sat_cnt
);

   localparam int CW = $clog2(RD_LAT + 1);
   localparam int PW = SUM_W - OUT_W + 2;

   localparam logic signed [SUM_W:0] HALF =
      {{SUM_W{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [SUM_W:0] MAXV =
      {{PW{1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SUM_W:0] MINV =
      {{PW{1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WAIT
   } state_t;

   state_t           state;
   logic [CW-1:0]    wcnt;
   logic [OUT_W-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       cnt_nxt;
   logic             push;
   logic             pop;

   logic signed [SUM_W:0] ext;
   logic signed [SUM_W:0] rnd;
   logic signed [SUM_W:0] shf;
   logic                  sat;
   logic [OUT_W-1:0]      res;

   // Extra sign bit keeps the rounding add from wrapping at +max.
   always_comb begin
      ext = {sum[SUM_W-1], sum};
`ifdef FIR_SUM_ROUND_EN
      rnd = ext + HALF;
`else
      rnd = ext;
`endif
      shf = rnd >>> SHIFT;
      sat = 1'b0;
      res = shf[OUT_W-1:0];
      if (shf > MAXV) begin
         sat = 1'b1;
         res = MAXV[OUT_W-1:0];
      end else if (shf < MINV) begin
         sat = 1'b1;
         res = MINV[OUT_W-1:0];
      end
   end

   assign push = (state == WAIT) &&
                 (wcnt == CW'(RD_LAT));
   assign pop  = out_valid & out_ready;

   always_comb begin
      cnt_nxt = count;
      if (push && !pop)
         cnt_nxt = count + 2'd1;
      else if (!push && pop)
         cnt_nxt = count - 2'd1;
   end

   assign out_data = mem[rd_ptr];

   always_ff @(posedge clk3) begin
      if (reset) begin
         state     <= IDLE;
         read      <= 1'b0;
         wcnt      <= '0;
         mem[0]    <= '0;
         mem[1]    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         out_valid <= 1'b0;
         sat_cnt   <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               // Buffer cannot fill while idle, so the
               // count check here guarantees room later.
               if (!empty && count < 2'd2) begin
                  state <= RD;
                  read  <= 1'b1;
               end
            end
            RD: begin
               read  <= 1'b0;
               state <= WAIT;
               wcnt  <= CW'(1);
            end
            WAIT: begin
               if (wcnt == CW'(RD_LAT))
                  state <= IDLE;
               else
                  wcnt <= wcnt + CW'(1);
            end
            default: begin
               state <= IDLE;
               read  <= 1'b0;
            end
         endcase

         if (push) begin
            mem[wr_ptr] <= res;
            wr_ptr      <= ~wr_ptr;
            if (sat && sat_cnt != 8'hFF)
               sat_cnt <= sat_cnt + 8'd1;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count     <= cnt_nxt;
         out_valid <= (cnt_nxt != 2'd0);
      end
   end

endmodule
